// File: rtl/dm_debug_ctrl_pkg.sv
// Shared types and default widths for the debug controller and the core's
// data/program memories.
package dm_debug_ctrl_pkg;

  localparam int DM_ADDR_W    = 4;
  localparam int DM_DATA_W    = 4;
  localparam int DM_PM_ADDR_W = DM_ADDR_W + DM_DATA_W;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_HALT  = 3'd1,
    OP_RUN   = 3'd2,
    OP_STEP  = 3'd3,
    OP_RD    = 3'd4,
    OP_WR    = 3'd5,
    OP_SETBP = 3'd6,
    OP_CLRBP = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_HALTED = 3'd1,
    ST_STEP   = 3'd2,
    ST_ACC    = 3'd3,
    ST_RSP    = 3'd4
  } dbg_state_e;

  // Commands that need the core parked; issued while running they are rejected.
  function automatic logic op_needs_halt(cmd_op_e op);
    return (op == OP_STEP) || (op == OP_RD) || (op == OP_WR);
  endfunction

endpackage

// File: rtl/dm_debug_ctrl_if.sv
// Host command/response port of the debug controller.
interface dm_debug_ctrl_if #(
  parameter int ADDR_W = dm_debug_ctrl_pkg::DM_ADDR_W,
  parameter int DATA_W = dm_debug_ctrl_pkg::DM_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/dm_debug_ctrl.sv
// Run/halt/step controller with program breakpoint and host access to the
// data memory while the core is parked.
module dm_debug_ctrl
  import dm_debug_ctrl_pkg::*;
#(
  parameter int ADDR_W       = DM_ADDR_W,
  parameter int DATA_W       = DM_DATA_W,
  parameter int PM_ADDR_W    = DM_PM_ADDR_W,
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dm_debug_ctrl_if.slave       host,
  input  logic [PM_ADDR_W-1:0] pm_addr,
  output logic                 core_en,
  output logic                 halted,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  input  logic                 cpu_we,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic [ADDR_W-1:0]    dm_addr,
  output logic [DATA_W-1:0]    dm_wdata,
  output logic                 dm_we,
  input  logic [DATA_W-1:0]    dm_rdata
);

  localparam dbg_state_e RST_STATE = RUN_ON_RESET ? ST_RUN : ST_HALTED;

  dbg_state_e           state_q, state_d, tgt_q, tgt_d, idle_tgt;
  logic                 skip_q, skip_d, bp_en_q, bp_en_d;
  logic [PM_ADDR_W-1:0] bp_addr_q, bp_addr_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 acc_we_q, acc_we_d;
  logic [ADDR_W-1:0]    acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0]    acc_wdata_q, acc_wdata_d;
  logic                 is_idle, accept, bp_hit;
  cmd_op_e              op;

  assign op      = cmd_op_e'(host.cmd_op);
  assign is_idle = (state_q == ST_RUN) || (state_q == ST_HALTED);
  assign accept  = host.cmd_valid && is_idle;
  assign bp_hit  = bp_en_q && (pm_addr == bp_addr_q) && !skip_q;

  // A breakpoint hit in RUN parks the core at this edge, whatever else is accepted.
  assign idle_tgt = (state_q == ST_RUN && !bp_hit) ? ST_RUN : ST_HALTED;

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    skip_d      = skip_q;
    bp_en_d     = bp_en_q;
    bp_addr_d   = bp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    acc_we_d    = acc_we_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    if (state_q == ST_RUN) skip_d = 1'b0;
    case (state_q)
      ST_RUN, ST_HALTED: begin
        state_d = idle_tgt;
        if (accept) begin
          state_d    = ST_RSP;
          tgt_d      = idle_tgt;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (op_needs_halt(op) && state_q == ST_RUN) begin
            rsp_err_d = 1'b1;
          end else begin
            case (op)
              OP_HALT: tgt_d = ST_HALTED;
              OP_RUN: begin
                tgt_d  = ST_RUN;
                skip_d = 1'b1;
              end
              OP_STEP: state_d = ST_STEP;
              OP_RD, OP_WR: begin
                state_d     = ST_ACC;
                acc_we_d    = (op == OP_WR);
                acc_addr_d  = host.cmd_addr;
                acc_wdata_d = host.cmd_data;
              end
              OP_SETBP: begin
                bp_en_d   = 1'b1;
                bp_addr_d = {host.cmd_addr, host.cmd_data};
              end
              OP_CLRBP: bp_en_d = 1'b0;
              default: ;
            endcase
          end
        end
      end
      ST_STEP: state_d = ST_RSP;
      ST_ACC: begin
        state_d    = ST_RSP;
        rsp_data_d = acc_we_q ? '0 : dm_rdata;
      end
      ST_RSP: if (host.rsp_ready) state_d = tgt_q;
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_STATE;
      tgt_q       <= RST_STATE;
      skip_q      <= 1'b0;
      bp_en_q     <= 1'b0;
      bp_addr_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      skip_q      <= skip_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      acc_we_q    <= acc_we_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
    end
  end

  assign host.cmd_ready = is_idle;
  assign host.rsp_valid = (state_q == ST_RSP);
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_err   = rsp_err_q;

  assign core_en   = (state_q == ST_RUN && !bp_hit) || (state_q == ST_STEP);
  assign halted    = !((state_q == ST_RUN) || (state_q == ST_STEP));
  assign cpu_rdata = dm_rdata;

  // Reset kills any in-flight write immediately, not at the next edge.
  always_comb begin
    dm_addr  = cpu_addr;
    dm_wdata = cpu_wdata;
    dm_we    = cpu_we && core_en;
    if (state_q == ST_ACC) begin
      dm_addr  = acc_addr_q;
      dm_wdata = acc_wdata_q;
      dm_we    = acc_we_q;
    end
    if (!reset_n) dm_we = 1'b0;
  end

endmodule

// File: tb/tb_dm_debug_ctrl.sv
// Bench for dm_debug_ctrl: simple PC-counter core, falling-edge 16x4 memory,
// directed steps then randomized host commands against a run/halt/memory model.
module tb_dm_debug_ctrl;
  import dm_debug_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  dm_debug_ctrl_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  logic [7:0] pm_addr;
  logic       core_en, halted, cpu_we, dm_we, pc_load;
  logic [3:0] cpu_addr, cpu_wdata, cpu_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [3:0] mem [16];
  logic [3:0] ref_mem [16];
  int         we_cnt = 0;
  int         leak_cnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  dm_debug_ctrl #(.ADDR_W(4), .DATA_W(4), .PM_ADDR_W(8), .RUN_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .host      (bus),
    .pm_addr   (pm_addr),
    .core_en   (core_en),
    .halted    (halted),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_we     (dm_we),
    .dm_rdata  (dm_rdata)
  );

  // Core stand-in: the program counter advances on every enabled edge.
  always @(posedge clk or negedge reset_n)
    if (!reset_n)     pm_addr <= 8'h00;
    else if (pc_load) pm_addr <= 8'h00;
    else if (core_en) pm_addr <= pm_addr + 8'd1;

  // Data memory on the falling edge; the core only ever writes address 15.
  always @(negedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
    dm_rdata <= mem[dm_addr];
    if (dm_we) we_cnt <= we_cnt + 1;
    if (dm_we && halted && dm_addr == 4'hF) leak_cnt <= leak_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input cmd_op_e op, input logic [3:0] a, input logic [3:0] d);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Issue one command, check the response and its latency, consume it; returns at a negedge.
  task automatic do_cmd(input cmd_op_e op, input logic [3:0] a, input logic [3:0] d,
                        input logic exp_err, input logic [3:0] exp_data, input int hold);
    int lat;
    send(op, a, d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 20);
    check("rsp_latency", lat, (!exp_err && op_needs_halt(op)) ? 2 : 1);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 1);
      check("hold_ready", 32'(bus.cmd_ready), 0);
      check("hold_rsp", 32'({bus.rsp_err, bus.rsp_data}), 32'({exp_err, exp_data}));
      check("hold_core_en", 32'(core_en), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         w0, n, v;
    logic [7:0] pc0;
    logic [3:0] a, d, xd;
    logic       e;
    bit         running, was_run;
    cmd_op_e    op;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_addr  = 4'h0;
    bus.cmd_data  = 4'h0;
    bus.rsp_ready = 1'b0;
    cpu_addr  = 4'hF;
    cpu_wdata = 4'h0;
    cpu_we    = 1'b1;
    pc_load   = 1'b0;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dm_we", 32'(dm_we), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_core_en", 32'(core_en), 1);
    check("rst_halted", 32'(halted), 0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_rsp_valid2", 32'(bus.rsp_valid), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);

    do_cmd(OP_HALT, 4'h0, 4'h0, 1'b0, 4'h0, 0);
    check("halt_halted", 32'(halted), 1);
    check("halt_core_en", 32'(core_en), 0);
    pc0 = pm_addr;
    repeat (3) @(negedge clk);
    check("halt_pc_frozen", 32'(pm_addr), 32'(pc0));

    w0 = we_cnt;
    do_cmd(OP_WR, 4'h3, 4'hA, 1'b0, 4'h0, 0);
    ref_mem[3] = 4'hA;
    check("wr_we_pulses", we_cnt - w0, 1);
    do_cmd(OP_RD, 4'h3, 4'h0, 1'b0, 4'hA, 2);

    for (int i = 0; i < 15; i++) begin
      if (i != 3) begin
        d = 4'($urandom);
        do_cmd(OP_WR, 4'(i), d, 1'b0, 4'h0, 0);
        ref_mem[i] = d;
      end
    end

    do_cmd(OP_RUN, 4'h0, 4'h0, 1'b0, 4'h0, 1);
    check("run_halted", 32'(halted), 0);
    cpu_we = 1'b0;
    w0 = we_cnt;
    do_cmd(OP_RD, 4'h7, 4'h0, 1'b1, 4'h0, 0);
    check("rd_run_no_we", we_cnt - w0, 0);
    check("rd_run_core_en", 32'(core_en), 1);
    check("rd_run_halted", 32'(halted), 0);
    cpu_we = 1'b1;

    // Breakpoint at 0x25 from pc 0, then resume past it.
    do_cmd(OP_HALT, 4'h0, 4'h0, 1'b0, 4'h0, 0);
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    check("pc_loaded", 32'(pm_addr), 0);
    do_cmd(OP_SETBP, 4'h2, 4'h5, 1'b0, 4'h0, 0);
    do_cmd(OP_RUN, 4'h0, 4'h0, 1'b0, 4'h0, 0);
    n = 0;
    while (halted !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_halted", 32'(halted), 1);
    check("bp_pc", 32'(pm_addr), 32'h25);
    repeat (3) @(negedge clk);
    check("bp_pc_held", 32'(pm_addr), 32'h25);
    check("bp_core_en", 32'(core_en), 0);
    do_cmd(OP_RUN, 4'h0, 4'h0, 1'b0, 4'h0, 0);
    repeat (5) @(negedge clk);
    check("resume_pc", 32'(pm_addr), 32'h2A);
    check("resume_halted", 32'(halted), 0);
    do_cmd(OP_HALT, 4'h0, 4'h0, 1'b0, 4'h0, 0);
    do_cmd(OP_CLRBP, 4'h0, 4'h0, 1'b0, 4'h0, 0);

    pc0 = pm_addr;
    w0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      cpu_wdata = 4'($urandom);
      do_cmd(OP_STEP, 4'h0, 4'h0, 1'b0, 4'h0, 0);
      check("step_halted", 32'(halted), 1);
    end
    check("step3_pc", 32'(pm_addr), 32'(8'(pc0 + 8'd3)));
    check("step3_we", we_cnt - w0, 3);

    running = 1'b0;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 6))
        0: op = OP_NOP;
        1: op = OP_HALT;
        2: op = OP_RUN;
        3: op = OP_STEP;
        4: op = OP_RD;
        5: op = OP_WR;
        default: op = OP_CLRBP;
      endcase
      a = 4'($urandom_range(0, 14));
      d = 4'($urandom);
      cpu_wdata = 4'($urandom);
      was_run = running;
      e  = running && (op == OP_STEP || op == OP_RD || op == OP_WR);
      xd = (op == OP_RD && !e) ? ref_mem[a] : 4'h0;
      pc0 = pm_addr;
      do_cmd(op, a, d, e, xd, int'($urandom_range(0, 3)));
      if (op == OP_HALT) running = 1'b0;
      else if (op == OP_RUN) running = 1'b1;
      if (op == OP_WR && !e) ref_mem[a] = d;
      check("rand_halted", 32'(halted), 32'(!running));
      if (!was_run && !running)
        check("rand_pc", 32'(pm_addr), 32'((op == OP_STEP) ? 8'(pc0 + 8'd1) : pc0));
    end
    check("no_halted_core_write", leak_cnt, 0);

    // Reset in the middle of a STEP: no response survives.
    if (running) do_cmd(OP_HALT, 4'h0, 4'h0, 1'b0, 4'h0, 0);
    send(OP_STEP, 4'h0, 4'h0);
    check("step_core_en", 32'(core_en), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_step_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_step_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_step_halted", 32'(halted), 0);
    check("rst_step_dm_we", 32'(dm_we), 0);
    @(negedge clk);
    reset_n = 1'b1;
    v = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) v++;
    end
    check("rst_step_no_rsp", v, 0);

    // Reset in the middle of a write access: the write must not land.
    do_cmd(OP_HALT, 4'h0, 4'h0, 1'b0, 4'h0, 0);
    send(OP_WR, 4'h5, ~ref_mem[5]);
    #1 reset_n = 1'b0;
    #1;
    check("rst_acc_dm_we", 32'(dm_we), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_cmd(OP_HALT, 4'h0, 4'h0, 1'b0, 4'h0, 0);
    do_cmd(OP_RD, 4'h5, 4'h0, 1'b0, ref_mem[5], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_debug_ctrl.md
# dm_debug_ctrl

Run/halt/step controller and data-memory arbiter for the 4-bit microprocessor core. It sits between the core, the 16x4 data memory and an external host command port. It gates core progress through a clock enable, supports a program-address breakpoint, and gives the host exclusive data-memory read/write access while the core is halted.

## Interface
Parameters:
- ADDR_W, 4, data-memory address width
- DATA_W, 4, data-memory word width
- PM_ADDR_W, 8, program-counter width (must equal 2*DATA_W... in practice ADDR_W+DATA_W)
- RUN_ON_RESET, 1, 1: leave reset in RUN; 0: leave reset in HALTED

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  command accepted when valid&ready at rising edge
- cmd_op  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 RD, 5 WR, 6 SETBP, 7 CLRBP
- cmd_addr  in  ADDR_W  RD/WR address; SETBP upper nibble
- cmd_data  in  DATA_W  WR data; SETBP lower nibble
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  host consumes response
- rsp_data  out  DATA_W  RD data, else 0
- rsp_err  out  1  command rejected
- pm_addr  in  PM_ADDR_W  core program counter
- core_en  out  1  core register clock enable
- halted  out  1  core is halted
- cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  core data-memory request
- cpu_we  in  1  core write enable
- cpu_rdata  out  DATA_W  equals dm_rdata, always
- dm_addr / dm_wdata  out  ADDR_W / DATA_W  to data memory
- dm_we  out  1  to data memory
- dm_rdata  in  DATA_W  from data memory (memory clocked on falling edge)

## Operation
- States: RUN, HALTED, STEP, ACC, RSP.
- Reset values:
  - State is RUN if RUN_ON_RESET, else HALTED.
  - rsp_valid=0, rsp_data=0, rsp_err=0, bp_en=0, bp_addr=0, skip=0.
- cmd_ready=1 only in RUN or HALTED.
- Every accepted command yields exactly one response through RSP. After rsp_valid&rsp_ready, return to the resolved state (RUN or HALTED).
- core_en = (RUN & !(bp_en & pm_addr==bp_addr & !skip)) | STEP. It is 0 in HALTED, ACC and RSP. In RSP, the target state governs nothing until exit.
- halted = !(state==RUN | state==STEP).
- Breakpoint: in RUN, a bp match goes to HALTED at the next edge. The core does not advance past bp_addr.
- Command behaviour:
  - HALT: valid in any state; target HALTED.
  - RUN: target RUN; set skip for the first RUN cycle so a resume from bp_addr advances.
  - STEP: only when halted. One STEP cycle with core_en=1, breakpoint ignored, then RSP → HALTED. When running: rsp_err=1, state unchanged.
  - RD/WR: only when halted, else rsp_err=1. ACC drives dm_addr=cmd_addr, dm_wdata=cmd_data, dm_we=(op==WR). rdata is captured at the end of ACC. For WR, rsp_data=0.
  - SETBP: bp_addr={cmd_addr,cmd_data}, bp_en=1. CLRBP: bp_en=0. Both are legal in any state. NOP: ok response.
- Mux: outside ACC, dm_* = cpu_*, with dm_we = cpu_we & core_en. A halted core never writes.

## Timing
- Command accepted at edge E0:
  - HALT/RUN/NOP/SETBP/CLRBP/errors: rsp_valid=1 from E0.
  - RD/WR: ACC during cycle E0–E1; rsp_valid from E1, RD data valid with it.
  - STEP: STEP during E0–E1; the core advances exactly once at E1; rsp_valid from E1.
- HALT accepted at E0: core_en=0 from E0. The core's last advance is at E0.
- Simultaneous bp match and HALT command at E0: HALT response, state HALTED, no error.
- rsp_valid with rsp_ready held low: response and outputs stable indefinitely; cmd_ready=0.
- reset_n asserted mid-ACC/STEP: immediate return to reset values; dm_we=0 asynchronously.

## Structure
- Shared package: opcode enum (cmd_op encodings), state enum, and the ADDR_W/DATA_W/PM_ADDR_W defaults shared with the core's data and program memories.
- Single module; no sub-module needed. The dm mux stays inline and combinational on registered state.

## Test plan
- RUN_ON_RESET=1, release reset_n → core_en=1, halted=0, cmd_ready=1, rsp_valid=0.
- HALT, then WR addr 3 data 0xA, then RD addr 3 → two ok responses; RD rsp_data=0xA, rsp_err=0; dm_we high exactly one cycle.
- RD while running → rsp_err=1, dm_we never asserted, core_en unaffected.
- SETBP 0x25, run from pc 0 → halted=1 with pm_addr=0x25; RUN → pc advances past 0x25 without re-halting.
- Halted, STEP three times → pm_addr advances exactly 3; cpu_we asserted while halted never reaches dm_we.
- STEP accepted, reset_n pulsed low during STEP → outputs at reset values, no response issued.
